uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
//
// PURPOSE
// Shares one UART transmitter among N_REQ byte requesters with round-robin fairness.
// Accepts one byte per valid/ready handshake, issues a one-cycle start pulse and byte to the transmitter, then waits for its done pulse.
// A watchdog aborts the wait if done never arrives.
// Sits between on-chip byte producers (command responder, status reporter, debug echo) and the UART transmit datapath, all in the system clk domain.
//
// PARAMETERS
// N_REQ          4     number of requesters, 2..8
// TIMEOUT_CYCLES 2048  clk cycles allowed from tx_start to tx_done; must exceed clk_freq/baud*10
//
// PORTS
// clk          in   1            system clock, all logic on posedge
// rst_n        in   1            asynchronous active-low reset
// req_valid    in   N_REQ        requester i has a byte pending
// req_data     in   8*N_REQ      byte of requester i on [8i+7:8i]
// req_ready    out  N_REQ        one-hot, one-cycle accept pulse to granted requester
// tx_start     out  1            one-cycle pulse: transmitter loads tx_data and starts a frame
// tx_data      out  8            byte for the transmitter, held stable until next grant
// tx_done      in   1            one-cycle pulse from transmitter: frame (incl. stop bit) finished
// grant_id     out  clog2(N_REQ) index of last granted requester
// busy         out  1            high while a frame is outstanding (WAIT state)
// timeout_err  out  1            one-cycle pulse: watchdog expired, frame abandoned
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, busy=0, timeout_err=0, timer=0, rr_ptr=N_REQ-1 (requester 0 wins first).
// - States: IDLE, WAIT. All outputs registered.
// - IDLE: on a posedge with any req_valid=1, winner g = first set index scanning rr_ptr+1, rr_ptr+2, ... (mod N_REQ).
//   - Next cycle: req_ready[g]=1, tx_start=1, tx_data=req_data[g], grant_id=g, busy=1.
//   - rr_ptr<=g, timer<=0, state<=WAIT.
//   - No valid: stay IDLE, all pulses 0.
// - Handshake: transfer happens when req_valid[g]&req_ready[g].
//   - Requester holds valid and data stable until ready. Withdrawing valid before ready is illegal; the byte is still sent.
//   - Requester must drop valid or present the next byte in the cycle after ready.
// - Latency: valid sampled at edge k -> req_ready/tx_start high in cycle k+1 (one cycle).
// - WAIT: req_ready=0, tx_start=0, timer increments each cycle, new requests ignored (remain pending).
//   - tx_done=1 -> state<=IDLE, busy<=0.
//   - timer==TIMEOUT_CYCLES-1 and tx_done=0 -> timeout_err=1 for one cycle, busy<=0, state<=IDLE.
//   - tx_done and timeout on the same edge: done wins, no error.
// - Back-to-back: tx_done in cycle d -> earliest next tx_start in cycle d+2.
// - tx_done received in IDLE: ignored, no state change.
// - Fairness: all requesters continuously valid -> grant order 0,1,2,...,N_REQ-1,0,...; no requester waits more than N_REQ-1 grants.
// - Timer width clog2(TIMEOUT_CYCLES); it cannot wrap because it is cleared on every grant.
// - Reset mid-frame: outstanding frame abandoned, no ready/err pulses, rr_ptr back to N_REQ-1.
//
// TESTING
// - Single request: req_valid=4'b0100, req_data[23:16]=8'hA5 -> next cycle req_ready=4'b0100, tx_start=1, tx_data=8'hA5, grant_id=2, busy=1.
//   tx_done 1040 cycles later -> busy=0 next cycle, no timeout_err.
// - Round-robin: all four valid continuously, done returned 1040 cycles after each start -> grant_id sequence 0,1,2,3,0,1; each tx_start gap = 1042 cycles.
// - Timeout: grant requester 1, never pulse tx_done -> timeout_err=1 exactly 2048 cycles after tx_start, busy=0; pending requester 2 granted two cycles later.
// - Done/timeout collision: tx_done on the cycle timer reaches 2047 -> no timeout_err, busy falls.
// - Stray done: pulse tx_done in IDLE with no requests -> all outputs unchanged.
// - Reset mid-WAIT: assert rst_n=0 for 3 cycles during a frame -> all outputs 0 immediately.
//   After release with all valid, first grant_id=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters,
// with a watchdog that abandons a frame whose done pulse never arrives.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [8*N_REQ-1:0]         i_req_data,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic                       o_tx_start,
    output logic [7:0]                 o_tx_data,
    input  logic                       i_tx_done,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id,
    output logic                       o_busy,
    output logic                       o_timeout_err
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     w_rr_ptr_nxt;
    logic [TW-1:0]      r_timer;
    logic [TW-1:0]      w_timer_nxt;
    logic [N_REQ-1:0]   r_req_ready;
    logic [N_REQ-1:0]   w_req_ready_nxt;
    logic               r_tx_start;
    logic               w_tx_start_nxt;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_tx_data_nxt;
    logic [IDW-1:0]     r_grant_id;
    logic [IDW-1:0]     w_grant_id_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_timeout_err;
    logic               w_timeout_err_nxt;

    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_cand;

    // Winner is the first valid requester after the last one granted.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            w_cand = IDW'((32'(r_rr_ptr) + i) % N_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_timer_nxt       = r_timer;
        w_req_ready_nxt   = '0;
        w_tx_start_nxt    = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        w_grant_id_nxt    = r_grant_id;
        w_busy_nxt        = r_busy;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = S_WAIT;
                    w_req_ready_nxt = ONE_HOT0 << w_win;
                    w_tx_start_nxt  = 1'b1;
                    w_tx_data_nxt   = i_req_data[8*32'(w_win) +: 8];
                    w_grant_id_nxt  = w_win;
                    w_busy_nxt      = 1'b1;
                    w_rr_ptr_nxt    = w_win;
                    w_timer_nxt     = '0;
                end
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + TW'(1);
                // A done arriving on the watchdog's last cycle still counts as success.
                if (i_tx_done) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (r_timer == T_LAST) begin
                    w_state_nxt       = S_IDLE;
                    w_busy_nxt        = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= IDW'(N_REQ - 1);
            r_timer       <= '0;
            r_req_ready   <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_grant_id    <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_timer       <= w_timer_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_grant_id    = r_grant_id;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against
// a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(2048)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .o_req_ready   (req_ready),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .i_tx_done     (tx_done),
        .o_grant_id    (grant_id),
        .o_busy        (busy),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tx_done   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Round-robin reference: first valid index after 'last', wrapping.
    function automatic int first_valid(input logic [3:0] v, input int last);
        for (int i = 1; i <= 4; i++) begin
            int idx;
            idx = (last + i) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        #2;
        n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
        n_total++; if (tx_start !== 1'b0) $display("FAIL reset_start: got %b want 0", tx_start); else n_pass++;
        n_total++; if (tx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", tx_data); else n_pass++;
        n_total++; if (grant_id !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_id); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_err: got %b want 0", timeout_err); else n_pass++;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int s;
        int bad;
        req_data        = $urandom;
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        tick();
        s = cyc;
        req_valid = '0;
        n_total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else n_pass++;
        n_total++; if (tx_start !== 1'b1) $display("FAIL single_start: got %b want 1", tx_start); else n_pass++;
        n_total++; if (tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", tx_data); else n_pass++;
        n_total++; if (grant_id !== 2'd2) $display("FAIL single_grant: got %0d want 2", grant_id); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        bad = 0;
        repeat (1040) begin
            tick();
            if (busy !== 1'b1 || tx_start !== 1'b0 || req_ready !== 4'b0000 || timeout_err !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL single_wait_hold: got %0d bad cycles want 0", bad); else n_pass++;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b want 0 (cycle %0d after start)", busy, cyc - s); else n_pass++;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL single_no_err: got %b want 0", timeout_err); else n_pass++;
    endtask

    task automatic test_round_robin();
        int s_prev;
        int m_last;
        int n;
        int g;
        logic [3:0] exp_rdy;
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'hF;
        m_last    = 3;
        s_prev    = 0;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            tick();
            while (tx_start !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            n_total++;
            if (tx_start !== 1'b1) begin
                $display("FAIL rr_start_timeout: got no start want start (grant %0d)", k);
                return;
            end else n_pass++;
            g       = first_valid(4'hF, m_last);
            exp_rdy = 4'b0001 << g;
            n_total++; if (grant_id !== 2'(g)) $display("FAIL rr_grant: got %0d want %0d (grant %0d)", grant_id, g, k); else n_pass++;
            n_total++; if (req_ready !== exp_rdy) $display("FAIL rr_ready: got %b want %b", req_ready, exp_rdy); else n_pass++;
            n_total++; if (tx_data !== req_data[8*g +: 8]) $display("FAIL rr_data: got %h want %h", tx_data, req_data[8*g +: 8]); else n_pass++;
            if (k > 0) begin
                n_total++; if (cyc - s_prev !== 1042) $display("FAIL rr_gap: got %0d want 1042", cyc - s_prev); else n_pass++;
            end
            s_prev = cyc;
            m_last = g;
            repeat (1040) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout_and_collision();
        int s;
        int n;
        int bad;
        do_reset();
        req_data[15:8] = 8'h5A;
        req_valid      = 4'b0010;
        tick();
        s = cyc;
        n_total++; if (tx_start !== 1'b1 || grant_id !== 2'd1) $display("FAIL to_grant1: got start=%b grant=%0d want start=1 grant=1", tx_start, grant_id); else n_pass++;
        req_valid       = 4'b0100;
        req_data[23:16] = 8'hC3;
        bad = 0;
        n   = 1;
        tick();
        while (timeout_err !== 1'b1 && n < 2100) begin
            if (tx_start !== 1'b0 || req_ready !== 4'b0000) bad++;
            tick();
            n++;
        end
        n_total++; if (timeout_err !== 1'b1) $display("FAIL to_err: got %b want 1", timeout_err); else n_pass++;
        n_total++; if (cyc - s !== 2048) $display("FAIL to_latency: got %0d want 2048", cyc - s); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL to_pending_held: got %0d bad cycles want 0", bad); else n_pass++;
        tick();
        n_total++; if (tx_start !== 1'b1) $display("FAIL to_next_start: got %b want 1", tx_start); else n_pass++;
        n_total++; if (grant_id !== 2'd2 || req_ready !== 4'b0100) $display("FAIL to_next_grant: got grant=%0d ready=%b want grant=2 ready=0100", grant_id, req_ready); else n_pass++;
        n_total++; if (tx_data !== 8'hC3 || timeout_err !== 1'b0) $display("FAIL to_next_data: got data=%h err=%b want data=c3 err=0", tx_data, timeout_err); else n_pass++;
        // Done arrives on the watchdog's final cycle of this second frame.
        req_valid = '0;
        repeat (2047) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL coll_no_err: got %b want 0", timeout_err); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL coll_busy: got %b want 0", busy); else n_pass++;
        bad = 0;
        repeat (3) begin
            tick();
            if (timeout_err !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL coll_late_err: got %0d err cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_stray_done();
        int bad;
        req_valid = '0;
        tx_done   = 1'b1;
        tick();
        tx_done = 1'b0;
        bad = 0;
        repeat (4) begin
            tick();
            if (tx_start !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL stray_pulses: got %0d bad cycles want 0", bad); else n_pass++;
        n_total++; if (tx_data !== 8'hC3 || grant_id !== 2'd2) $display("FAIL stray_hold: got data=%h grant=%0d want data=c3 grant=2", tx_data, grant_id); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        logic [16:0] outs;
        do_reset();
        req_data  = $urandom;
        req_valid = 4'hF;
        tick();
        tick();
        req_valid = 4'b1110;
        repeat (5) tick();
        n_total++; if (busy !== 1'b1) $display("FAIL rst_mid_pre_busy: got %b want 1", busy); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        outs = {req_ready, tx_start, tx_data, grant_id, busy, timeout_err};
        n_total++; if (outs !== 17'd0) $display("FAIL rst_mid_outputs: got %h want 0", outs); else n_pass++;
        req_valid = 4'hF;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_total++; if (tx_start !== 1'b1 || grant_id !== 2'd0) $display("FAIL rst_mid_first_grant: got start=%b grant=%0d want start=1 grant=0", tx_start, grant_id); else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_random();
        int         cnt[4];
        logic [7:0] cur[4];
        logic [3:0] prev_valid;
        logic [31:0] prev_data;
        logic       prev_done;
        logic       m_wait;
        logic       m_wait_new;
        logic       exp_start;
        logic [3:0] exp_rdy;
        int         m_last;
        int         grants;
        int         guard;
        int         done_at;
        int         g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cnt[i] = $urandom_range(0, 5);
            cur[i] = 8'($urandom);
        end
        m_wait  = 1'b0;
        m_last  = 3;
        grants  = 0;
        guard   = 0;
        done_at = -1;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (cnt[i] > 0);
            req_data[8*i +: 8] = cur[i];
        end
        prev_valid = req_valid;
        prev_data  = req_data;
        prev_done  = 1'b0;
        while (grants < 40 && guard < 4000) begin
            tick();
            guard++;
            exp_start  = !m_wait && (prev_valid != 4'b0000);
            m_wait_new = exp_start ? 1'b1 : (prev_done ? 1'b0 : m_wait);
            n_total++; if (tx_start !== exp_start) $display("FAIL rand_start: got %b want %b (cycle %0d)", tx_start, exp_start, guard); else n_pass++;
            n_total++; if (busy !== m_wait_new || timeout_err !== 1'b0) $display("FAIL rand_busy: got busy=%b err=%b want busy=%b err=0", busy, timeout_err, m_wait_new); else n_pass++;
            if (exp_start) begin
                g       = first_valid(prev_valid, m_last);
                exp_rdy = 4'b0001 << g;
                n_total++; if (grant_id !== 2'(g) || req_ready !== exp_rdy) $display("FAIL rand_grant: got grant=%0d ready=%b want grant=%0d ready=%b", grant_id, req_ready, g, exp_rdy); else n_pass++;
                n_total++; if (tx_data !== prev_data[8*g +: 8]) $display("FAIL rand_data: got %h want %h", tx_data, prev_data[8*g +: 8]); else n_pass++;
                m_last  = g;
                cnt[g]  = cnt[g] - 1;
                cur[g]  = 8'($urandom);
                done_at = guard + $urandom_range(1, 30);
                grants++;
            end else begin
                n_total++; if (req_ready !== 4'b0000) $display("FAIL rand_ready_idle: got %b want 0000", req_ready); else n_pass++;
            end
            m_wait  = m_wait_new;
            tx_done = (m_wait && guard == done_at) || (!m_wait && $urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) begin
                if (cnt[i] == 0 && $urandom_range(0, 3) == 0) cnt[i] = $urandom_range(1, 3);
                req_valid[i]       = (cnt[i] > 0);
                req_data[8*i +: 8] = cur[i];
            end
            prev_valid = req_valid;
            prev_data  = req_data;
            prev_done  = tx_done;
        end
        n_total++; if (grants !== 40) $display("FAIL rand_progress: got %0d grants want 40", grants); else n_pass++;
        tx_done   = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout_and_collision();
        test_stray_done();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
